// File: rtl/gb_line_write_sched.sv
// gb_line_write_sched: packs one captured Game Boy line (160 px, two bit-planes)
// into 40 bytes and writes them to the display RAM while the VGA write window
// is open. On request, it also mirrors one complete frame into the screenshot RAM.
`timescale 1ns/1ps
module gb_line_write_sched #(
    parameter int LINE_BYTES = 40,
    parameter int LINES      = 144,
    parameter int ADDR_W     = 13
) (
    input  logic              pixel_clk,
    input  logic              reset_n,
    input  logic              line_valid,
    input  logic [7:0]        line_num,
    input  logic [159:0]      line_pix0,
    input  logic [159:0]      line_pix1,
    output logic              line_ack,
    input  logic              wr_window,
    output logic              disp_wren,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [7:0]        disp_data,
    output logic              ss_wren,
    input  logic              snap_req,
    output logic              snap_busy,
    output logic              snap_done,
    output logic [7:0]        drop_cnt
);

    typedef enum logic [1:0] {IDLE, WRITE, ACK, RELEASE} line_state_e;
    typedef enum logic [1:0] {SS_IDLE, SS_ARMED, SS_CAPT} ss_state_e;

    localparam logic [5:0] LAST_BYTE = 6'(LINE_BYTES - 1);
    localparam logic [7:0] LINES_B   = 8'(LINES);
    localparam logic [7:0] LAST_LINE = 8'(LINES - 1);

    line_state_e       state_q;
    ss_state_e         ss_q;
    logic [5:0]        k_q;
    logic [7:0]        num_q;
    logic [ADDR_W-1:0] base_q;
    logic [159:0]      pix0_q;
    logic [159:0]      pix1_q;
    logic              wren_q;
    logic              ss_wren_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;
    logic              ack_q;
    logic              done_q;
    logic [7:0]        drop_q;

    logic [7:0]        bit_idx;
    logic [3:0]        nib0;
    logic [3:0]        nib1;
    logic [7:0]        byte_d;
    logic [ADDR_W-1:0] base_d;
    logic              line_ok;

    // Byte k is formed from pixels 4k..4k+3, with the two planes interleaved and the lowest pixel in the MSBs.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        bit_idx = {k_q, 2'b00};
        nib0    = pix0_q[bit_idx +: 4];
        nib1    = pix1_q[bit_idx +: 4];
        byte_d  = {nib0[0], nib1[0], nib0[1], nib1[1], nib0[2], nib1[2], nib0[3], nib1[3]};
        base_d  = ADDR_W'(line_num) * ADDR_W'(LINE_BYTES);
        line_ok = (line_num < LINES_B);
    end

    // Line FSM: accepts a line, streams its 40 bytes through the write window, then acks it and waits for valid to drop.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            k_q       <= '0;
            num_q     <= '0;
            base_q    <= '0;
            // NOTE: the latched planes are ordinary flops rather than a RAM, so they take the async reset like everything else.
            pix0_q    <= '0;
            pix1_q    <= '0;
            wren_q    <= 1'b0;
            ss_wren_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            ack_q     <= 1'b0;
            drop_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments everywhere here, so every branch sees the pre-edge state.
            wren_q    <= 1'b0;
            ss_wren_q <= 1'b0;
            ack_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (line_valid) begin
                        num_q  <= line_num;
                        pix0_q <= line_pix0;
                        pix1_q <= line_pix1;
                        base_q <= base_d;
                        k_q    <= '0;
                        if (line_ok) begin
                            state_q <= WRITE;
                        end else begin
                            state_q <= ACK;
                            if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
                        end
                    end
                end
                WRITE: begin
                    if (wr_window) begin
                        wren_q    <= 1'b1;
                        ss_wren_q <= (ss_q == SS_CAPT);
                        addr_q    <= base_q + ADDR_W'(k_q);
                        data_q    <= byte_d;
                        k_q       <= k_q + 6'd1;
                        if (k_q == LAST_BYTE) state_q <= ACK;
                    end
                end
                ACK: begin
                    ack_q   <= 1'b1;
                    state_q <= RELEASE;
                end
                RELEASE: begin
                    if (!line_valid) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Screenshot FSM: arms on request, starts capturing at the next accepted line 0, and finishes on line 143's ack.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            ss_q   <= SS_IDLE;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (ss_q)
                SS_IDLE: begin
                    if (snap_req) ss_q <= SS_ARMED;
                end
                SS_ARMED: begin
                    if (state_q == IDLE && line_valid && line_num == 8'd0) ss_q <= SS_CAPT;
                end
                SS_CAPT: begin
                    if (state_q == ACK && num_q == LAST_LINE) begin
                        ss_q   <= SS_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: ss_q <= SS_IDLE;
            endcase
        end
    end

    assign line_ack  = ack_q;
    assign disp_wren = wren_q;
    assign disp_addr = addr_q;
    assign disp_data = data_q;
    assign ss_wren   = ss_wren_q;
    assign snap_busy = (ss_q != SS_IDLE);
    assign snap_done = done_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_gb_line_write_sched.sv
// Randomized self-checking bench for gb_line_write_sched. A behavioural model
// lists each accepted line's expected writes and tracks the snapshot and drop rules.
`timescale 1ns/1ps
module tb_gb_line_write_sched;

    localparam int LINE_BYTES = 40;
    localparam int LINES      = 144;
    localparam int ADDR_W     = 13;
    localparam int MAX_CYC    = 1000;

    logic              pixel_clk = 1'b0;
    logic              reset_n   = 1'b0;
    logic              line_valid = 1'b0;
    logic [7:0]        line_num  = '0;
    logic [159:0]      line_pix0 = '0;
    logic [159:0]      line_pix1 = '0;
    logic              wr_window = 1'b0;
    logic              snap_req  = 1'b0;
    logic              line_ack;
    logic              disp_wren;
    logic [ADDR_W-1:0] disp_addr;
    logic [7:0]        disp_data;
    logic              ss_wren;
    logic              snap_busy;
    logic              snap_done;
    logic [7:0]        drop_cnt;

    int   checks = 0;
    int   errors = 0;
    int   drops_m;
    bit   armed_m;
    bit   capt_m;
    logic [7:0] first_byte;

    always #5 pixel_clk = ~pixel_clk;

    gb_line_write_sched #(
        .LINE_BYTES(LINE_BYTES),
        .LINES     (LINES),
        .ADDR_W    (ADDR_W)
    ) dut (
        .pixel_clk (pixel_clk),
        .reset_n   (reset_n),
        .line_valid(line_valid),
        .line_num  (line_num),
        .line_pix0 (line_pix0),
        .line_pix1 (line_pix1),
        .line_ack  (line_ack),
        .wr_window (wr_window),
        .disp_wren (disp_wren),
        .disp_addr (disp_addr),
        .disp_data (disp_data),
        .ss_wren   (ss_wren),
        .snap_req  (snap_req),
        .snap_busy (snap_busy),
        .snap_done (snap_done),
        .drop_cnt  (drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Byte b holds pixels 4b..4b+3, pixel order from MSB down, plane 0 ahead of plane 1.
    function automatic logic [7:0] pack_byte(input logic [159:0] p0, input logic [159:0] p1, input int b);
        logic [7:0] v;
        v = '0;
        for (int j = 0; j < 4; j++) v = {v[5:0], p0[4*b+j], p1[4*b+j]};
        return v;
    endfunction

    function automatic logic [159:0] rnd160();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // mode 0: window always open; 1: 5 open / 5 closed; otherwise open with probability 3/4
    function automatic bit win_at(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (((c - 1) / 5) % 2) == 0;
            default: return $urandom_range(3) != 0;
        endcase
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_disp_wren", disp_wren, 0);
        check("rst_ss_wren",   ss_wren,   0);
        check("rst_disp_addr", disp_addr, 0);
        check("rst_disp_data", disp_data, 0);
        check("rst_line_ack",  line_ack,  0);
        check("rst_snap_busy", snap_busy, 0);
        check("rst_snap_done", snap_done, 0);
        check("rst_drop_cnt",  drop_cnt,  0);
        line_valid = 1'b0;
        snap_req   = 1'b0;
        wr_window  = 1'b0;
        drops_m    = 0;
        armed_m    = 1'b0;
        capt_m     = 1'b0;
        @(negedge pixel_clk);
        reset_n = 1'b1;
        @(negedge pixel_clk);
    endtask

    task automatic snap_pulse();
        snap_req = 1'b1;
        if (!armed_m && !capt_m) armed_m = 1'b1;
        @(negedge pixel_clk);
        snap_req = 1'b0;
        check("snap_busy_req", snap_busy, armed_m || capt_m);
    endtask

    // Offers one line and checks every cycle until its ack. Optionally it holds valid,
    // or aborts with a reset after abort_after writes.
    task automatic run_line(input logic [7:0] num, input logic [159:0] p0, input logic [159:0] p1,
                            input int mode, input bit snap, input int abort_after, input int hold);
        bit drop;
        bit win;
        bit exp_wren;
        bit capt_line;
        bit done_exp;
        int idx;
        int ack_at;
        int c;
        int nwr;
        int nack;
        drop   = (num >= LINES);
        idx    = 0;
        ack_at = drop ? 1 : -1;
        line_valid = 1'b1;
        line_num   = num;
        line_pix0  = p0;
        line_pix1  = p1;
        snap_req   = snap;
        if (armed_m && num == 0) begin
            armed_m = 1'b0;
            capt_m  = 1'b1;
        end else if (!armed_m && !capt_m && snap) begin
            armed_m = 1'b1;
        end
        if (drop && drops_m < 255) drops_m++;
        capt_line = capt_m;
        done_exp  = 1'b0;
        for (c = 0; c <= MAX_CYC; c++) begin
            win = win_at(mode, c);
            wr_window = win;
            @(negedge pixel_clk);
            snap_req = 1'b0;
            if (c == 0) begin
                check("drop_cnt", drop_cnt, drops_m);
                check("snap_busy", snap_busy, armed_m || capt_m);
            end else begin
                exp_wren = !drop && win && (idx < LINE_BYTES);
                check("disp_wren", disp_wren, exp_wren);
                check("ss_wren", ss_wren, exp_wren && capt_line);
                if (exp_wren) begin
                    check("disp_addr", disp_addr, num * LINE_BYTES + idx);
                    check("disp_data", disp_data, pack_byte(p0, p1, idx));
                    if (idx == 0) first_byte = disp_data;
                    idx++;
                    if (idx == LINE_BYTES) ack_at = c + 1;
                    if (abort_after > 0 && idx == abort_after) begin
                        do_reset();
                        return;
                    end
                end
                done_exp = (c == ack_at) && capt_line && (num == LINES - 1);
                check("line_ack", line_ack, c == ack_at);
                check("snap_done", snap_done, done_exp);
                if (c == ack_at) break;
            end
        end
        if (c > MAX_CYC) check("ack_timeout", line_ack, 1);
        if (done_exp) capt_m = 1'b0;
        nwr  = 0;
        nack = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge pixel_clk);
            nwr  += int'(disp_wren);
            nack += int'(line_ack);
        end
        if (hold > 0) begin
            check("hold_wren", nwr, 0);
            check("hold_ack", nack, 0);
        end
        line_valid = 1'b0;
        @(negedge pixel_clk);
        check("ack_pulse", line_ack, 0);
        check("release_wren", disp_wren, 0);
        check("release_busy", snap_busy, armed_m || capt_m);
    endtask

    initial begin
        logic [159:0] p0;
        logic [159:0] p1;
        drops_m = 0;
        armed_m = 1'b0;
        capt_m  = 1'b0;
        #2;
        do_reset();

        // Line 0 with a known first byte, window held open
        p0 = '0;
        p0[0] = 1'b1;
        p0[1] = 1'b1;
        p1 = '0;
        p1[1] = 1'b1;
        run_line(8'd0, p0, p1, 0, 1'b0, 0, 0);
        check("line0_byte0", first_byte, 8'hB0);

        // Last line with a 5-on / 5-off window
        run_line(8'd143, rnd160(), rnd160(), 1, 1'b0, 0, 0);

        // Dropped lines and saturation of the drop counter
        run_line(8'd200, rnd160(), rnd160(), 0, 1'b0, 0, 0);
        check("drop_one", drop_cnt, 1);
        for (int i = 0; i < 299; i++)
            run_line(8'($urandom_range(255, 144)), rnd160(), rnd160(), 0, 1'b0, 0, 0);
        check("drop_sat", drop_cnt, 255);

        // Valid held high after the ack, then a fresh line 5
        run_line(8'd7, rnd160(), rnd160(), 2, 1'b0, 0, 100);
        run_line(8'd5, rnd160(), rnd160(), 0, 1'b0, 0, 0);

        // Random lines under a random window
        for (int i = 0; i < 6; i++)
            run_line(8'($urandom_range(143, 0)), rnd160(), rnd160(), 2, 1'b0, 0, 0);

        // Snapshot requested mid-frame: the rest of this frame is skipped and the next frame is captured
        snap_pulse();
        for (int n = 100; n < LINES; n++)
            run_line(8'(n), rnd160(), rnd160(), 2, 1'b0, 0, 0);
        for (int n = 0; n < LINES; n++)
            run_line(8'(n), rnd160(), rnd160(), 2, 1'b0, 0, 0);
        check("snap_busy_after", snap_busy, 0);

        // Snapshot request on the same edge as a line-0 accept only arms
        run_line(8'd0, rnd160(), rnd160(), 0, 1'b1, 0, 0);
        for (int n = 1; n < 4; n++)
            run_line(8'(n), rnd160(), rnd160(), 2, 1'b0, 0, 0);
        check("snap_armed", snap_busy, 1);

        // Reset after 10 writes of line 3, then the same line is offered again
        p0 = rnd160();
        p1 = rnd160();
        run_line(8'd3, p0, p1, 0, 1'b0, 10, 0);
        run_line(8'd3, p0, p1, 0, 1'b0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
